// File: rtl/stage_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : stage_mem_access
// Brief   : RV32I MEM stage: data-memory handshake, store lane alignment,
//           load formatting and the registered MEM/WB result.
// Revision: 1.0
// ============================================================================
module stage_mem_access #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   valid_in,
    input  logic [31:0]            alu_result_in,
    input  logic [31:0]            rs2_data_in,
    input  logic [4:0]             rd_in,
    input  logic                   reg_write_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [2:0]             funct3_in,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [31:0]            dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_be,
    input  logic                   dmem_ready,
    input  logic [31:0]            dmem_rdata,
    output logic [31:0]            wb_data_out,
    output logic [4:0]             rd_out,
    output logic                   reg_write_out,
    output logic                   valid_out,
    output logic                   mem_busy,
    output logic                   mem_exc,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_flushed;
    logic [31:0]            r_wb_data;
    logic [4:0]             r_rd;
    logic                   r_reg_write;
    logic                   r_valid;
    logic                   r_mem_exc;
    logic [STALL_CNT_W-1:0] r_stall;

    logic        w_mem_op;
    logic        w_bad;
    logic        w_start;
    logic        w_is_store;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    assign w_mem_op   = valid_in & (mem_read_in | mem_write_in);
    assign w_is_store = mem_write_in;

    always_comb begin
        w_bad = 1'b0;
        case (funct3_in)
            3'b011, 3'b110, 3'b111: w_bad = 1'b1;
            c_F3_H, c_F3_HU:        w_bad = alu_result_in[0];
            c_F3_W:                 w_bad = (alu_result_in[1:0] != 2'b00);
            default:                w_bad = 1'b0;
        endcase
        w_bad = w_bad & w_mem_op;
    end

    assign w_start = w_mem_op & ~w_bad & ~flush;

    // Stores pick lanes by access size; loads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_in;
        if (w_is_store) begin
            case (funct3_in[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << alu_result_in[1:0];
                    w_wdata = {4{rs2_data_in[7:0]}};
                end
                2'b01: begin
                    w_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{rs2_data_in[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = rs2_data_in;
                end
            endcase
        end
    end

    always_comb begin
        w_ld_byte = dmem_rdata[7:0];
        case (alu_result_in[1:0])
            2'b00:   w_ld_byte = dmem_rdata[7:0];
            2'b01:   w_ld_byte = dmem_rdata[15:8];
            2'b10:   w_ld_byte = dmem_rdata[23:16];
            default: w_ld_byte = dmem_rdata[31:24];
        endcase
        w_ld_half = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_ld_data = dmem_rdata;
        case (funct3_in)
            c_F3_B:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_F3_H:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            c_F3_BU: w_ld_data = {24'd0, w_ld_byte};
            c_F3_HU: w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_flushed   <= 1'b0;
            r_wb_data   <= 32'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_mem_exc   <= 1'b0;
            r_stall     <= '0;
        end else begin
            r_mem_exc   <= 1'b0;
            r_wb_data   <= 32'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (w_bad) begin
                        r_mem_exc <= 1'b1;
                    end else if (w_mem_op) begin
                        r_state   <= S_WAIT;
                        r_flushed <= 1'b0;
                    end else begin
                        r_wb_data   <= alu_result_in;
                        r_rd        <= rd_in;
                        r_reg_write <= reg_write_in & valid_in;
                        r_valid     <= valid_in;
                    end
                end
                S_WAIT: begin
                    if (r_stall != {STALL_CNT_W{1'b1}}) begin
                        r_stall <= r_stall + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    // A flush seen on any WAIT cycle squashes the result, not the access.
                    if (dmem_ready) begin
                        r_state <= S_IDLE;
                        if (!(flush || r_flushed)) begin
                            r_valid <= 1'b1;
                            r_rd    <= rd_in;
                            if (w_is_store) begin
                                r_wb_data   <= alu_result_in;
                                r_reg_write <= 1'b0;
                            end else begin
                                r_wb_data   <= w_ld_data;
                                r_reg_write <= reg_write_in;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req      = (r_state == S_WAIT);
    assign dmem_we       = dmem_req & mem_write_in;
    assign dmem_addr     = {alu_result_in[31:2], 2'b00};
    assign dmem_wdata    = w_wdata;
    assign dmem_be       = w_be;
    assign mem_busy      = (r_state == S_IDLE) ? w_start : ~dmem_ready;
    assign wb_data_out   = r_wb_data;
    assign rd_out        = r_rd;
    assign reg_write_out = r_reg_write;
    assign valid_out     = r_valid;
    assign mem_exc       = r_mem_exc;
    assign stall_cycles  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_stage_mem_access
// Brief   : Self-checking bench: directed vector table, hand sequences and
//           randomized ops against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_stage_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        valid_out;
    logic        mem_busy;
    logic        mem_exc;
    logic [31:0] stall_cycles;

    int          n_chk = 0;
    int          n_err = 0;
    int unsigned exp_stall = 0;

    always #5 clk = ~clk;

    stage_mem_access #(.STALL_CNT_W(32)) dut (
        .clk(clk), .reset(rst), .flush(flush), .valid_in(valid_in),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .funct3_in(funct3_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .wb_data_out(wb_data_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .valid_out(valid_out),
        .mem_busy(mem_busy), .mem_exc(mem_exc), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic        v, rd_en, wr_en, rw, fl_idle;
        logic [2:0]  f3;
        logic [31:0] alu, rs2, rdata;
        logic [4:0]  rd;
        int          dly;
        int          fl_k;
        logic [31:0] e_wb;
        logic        e_rw, e_val, e_exc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, rd_en, wr_en, rw, input logic [2:0] f3,
                                input logic [31:0] alu, rs2, rdata, input logic [4:0] rd,
                                input int dly, input logic fl_idle, input int fl_k,
                                input logic [31:0] e_wb, input logic e_rw, e_val, e_exc);
        vec_t t;
        t.v = v; t.rd_en = rd_en; t.wr_en = wr_en; t.rw = rw; t.f3 = f3;
        t.alu = alu; t.rs2 = rs2; t.rdata = rdata; t.rd = rd; t.dly = dly;
        t.fl_idle = fl_idle; t.fl_k = fl_k;
        t.e_wb = e_wb; t.e_rw = e_rw; t.e_val = e_val; t.e_exc = e_exc;
        return t;
    endfunction

    function automatic bit is_mem(vec_t t);
        return t.v && (t.rd_en || t.wr_en);
    endfunction

    function automatic bit is_bad(vec_t t);
        int a = int'(t.alu % 4);
        if (!is_mem(t)) return 0;
        if (t.f3 == 3 || t.f3 == 6 || t.f3 == 7) return 1;
        if ((t.f3 == 1 || t.f3 == 5) && (a % 2) != 0) return 1;
        if (t.f3 == 2 && a != 0) return 1;
        return 0;
    endfunction

    function automatic bit goes_wait(vec_t t);
        return is_mem(t) && !is_bad(t) && !t.fl_idle;
    endfunction

    function automatic logic [3:0] exp_be(vec_t t);
        int a = int'(t.alu % 4);
        if (!t.wr_en) return 4'hF;
        case (t.f3 % 4)
            0:       return 4'(1 << a);
            1:       return (a >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(vec_t t);
        if (!t.wr_en) return t.rs2;
        case (t.f3 % 4)
            0:       return (t.rs2 % 256) * 32'h0101_0101;
            1:       return (t.rs2 % 65536) * 32'h0001_0001;
            default: return t.rs2;
        endcase
    endfunction

    // Reference: result of one instruction from the architectural rules.
    function automatic vec_t model(vec_t t);
        vec_t r = t;
        int   a = int'(t.alu % 4);
        int   b = int'((t.rdata >> (8 * a)) % 256);
        int   h = int'((t.rdata >> (16 * (a / 2))) % 65536);
        r.e_wb = 0; r.e_rw = 0; r.e_val = 0; r.e_exc = 0;
        if (t.fl_idle) return r;
        if (is_bad(t)) begin
            r.e_exc = 1;
        end else if (is_mem(t)) begin
            if (t.fl_k >= 0 && t.fl_k <= t.dly) return r;
            r.e_val = 1;
            if (t.wr_en) begin
                r.e_rw = 0;
            end else begin
                r.e_rw = t.rw;
                case (t.f3)
                    0:       r.e_wb = (b >= 128) ? 32'(b - 256) : 32'(b);
                    1:       r.e_wb = (h >= 32768) ? 32'(h - 65536) : 32'(h);
                    4:       r.e_wb = 32'(b);
                    5:       r.e_wb = 32'(h);
                    default: r.e_wb = t.rdata;
                endcase
            end
        end else begin
            r.e_val = t.v;
            r.e_rw  = t.v && t.rw;
            r.e_wb  = t.alu;
        end
        return r;
    endfunction

    task automatic apply(input vec_t t, input string nm);
        bit go = goes_wait(t);
        valid_in = t.v; alu_result_in = t.alu; rs2_data_in = t.rs2; rd_in = t.rd;
        reg_write_in = t.rw; mem_read_in = t.rd_en; mem_write_in = t.wr_en;
        funct3_in = t.f3; flush = t.fl_idle;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #4;
        chk({nm, " busy_idle"}, 32'(mem_busy), 32'(go));
        chk({nm, " req_idle"}, 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        if (go) begin
            for (int k = 0; k <= t.dly; k++) begin
                flush      = (k == t.fl_k);
                dmem_ready = (k == t.dly);
                dmem_rdata = t.rdata;
                #4;
                chk({nm, " req"}, 32'(dmem_req), 32'd1);
                chk({nm, " we"}, 32'(dmem_we), 32'(t.wr_en));
                chk({nm, " addr"}, dmem_addr, t.alu & 32'hFFFF_FFFC);
                chk({nm, " be"}, 32'(dmem_be), 32'(exp_be(t)));
                if (t.wr_en) chk({nm, " wdata"}, dmem_wdata, exp_wdata(t));
                chk({nm, " busy_wait"}, 32'(mem_busy), 32'(k != t.dly));
                @(posedge clk); #1;
                exp_stall++;
            end
        end
        valid_in = 1'b0; flush = 1'b0; dmem_ready = 1'b0;
        chk({nm, " valid_out"}, 32'(valid_out), 32'(t.e_val));
        chk({nm, " reg_write_out"}, 32'(reg_write_out), 32'(t.e_rw));
        chk({nm, " mem_exc"}, 32'(mem_exc), 32'(t.e_exc));
        chk({nm, " stall"}, stall_cycles, exp_stall);
        if (t.e_val && t.e_rw) begin
            chk({nm, " wb_data"}, wb_data_out, t.e_wb);
            chk({nm, " rd_out"}, 32'(rd_out), 32'(t.rd));
        end
        @(posedge clk); #1;
        chk({nm, " exc_pulse_end"}, 32'(mem_exc), 32'd0);
        chk({nm, " bubble_after"}, 32'(valid_out), 32'd0);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; alu_result_in = '0; rs2_data_in = '0;
        rd_in = '0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset wb_data", wb_data_out, 32'd0);
        chk("reset req", 32'(dmem_req), 32'd0);
        chk("reset stall", stall_cycles, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //        v rd wr rw f3      alu           rs2            rdata          rd dly fi fk  e_wb         rw val exc
        tbl.push_back(mk(1,0,0,1,3'b000,32'h1234,     32'h0,        32'h0,         5,0, 0,-1, 32'h1234,    1,1,0));
        tbl.push_back(mk(1,1,0,1,3'b000,32'h103,      32'h0,        32'h80FF_FF00, 7,0, 0,-1, 32'hFFFFFF80,1,1,0));
        tbl.push_back(mk(1,1,0,1,3'b100,32'h103,      32'h0,        32'h80FF_FF00, 7,0, 0,-1, 32'h00000080,1,1,0));
        tbl.push_back(mk(1,0,1,0,3'b001,32'h202,      32'hABCD,     32'h0,         0,3, 0,-1, 32'h0,       0,1,0));
        tbl.push_back(mk(1,1,0,1,3'b010,32'h101,      32'h0,        32'h0,         3,0, 0,-1, 32'h0,       0,0,1));
        tbl.push_back(mk(1,0,1,0,3'b010,32'h300,      32'h11223344, 32'h0,         0,2, 0, 0, 32'h0,       0,0,0));
        tbl.push_back(mk(1,0,1,0,3'b010,32'h304,      32'h55667788, 32'h0,         0,2, 0, 1, 32'h0,       0,0,0));
        tbl.push_back(mk(1,1,0,1,3'b010,32'h100,      32'h0,        32'h12345678,  4,0, 1,-1, 32'h0,       0,0,0));
        tbl.push_back(mk(1,1,0,1,3'b001,32'h102,      32'h0,        32'h8001_7FFF, 9,0, 0,-1, 32'hFFFF8001,1,1,0));
        tbl.push_back(mk(1,1,0,1,3'b101,32'h102,      32'h0,        32'h8001_7FFF, 9,1, 0,-1, 32'h00008001,1,1,0));
        tbl.push_back(mk(1,1,0,1,3'b010,32'h104,      32'h0,        32'hDEAD_BEEF, 2,1, 0,-1, 32'hDEADBEEF,1,1,0));
        tbl.push_back(mk(1,1,0,1,3'b011,32'h100,      32'h0,        32'h0,         2,0, 0,-1, 32'h0,       0,0,1));
        tbl.push_back(mk(1,1,0,1,3'b001,32'h103,      32'h0,        32'h0,         2,0, 0,-1, 32'h0,       0,0,1));
        tbl.push_back(mk(0,1,0,1,3'b010,32'h100,      32'h0,        32'h0,         2,0, 0,-1, 32'h0,       0,0,0));
        tbl.push_back(mk(1,0,1,0,3'b000,32'h101,      32'h5A,       32'h0,         0,0, 0,-1, 32'h0,       0,1,0));
        tbl.push_back(mk(1,1,0,1,3'b000,32'h101,      32'h0,        32'h0000_7F00, 6,0, 0,-1, 32'h0000007F,1,1,0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while a store is waiting on memory.
        valid_in = 1'b1; mem_write_in = 1'b1; mem_read_in = 1'b0; funct3_in = 3'b010;
        alu_result_in = 32'h400; rs2_data_in = 32'hCAFE_F00D; dmem_ready = 1'b0;
        @(posedge clk); #1;
        chk("rstwait in_wait", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 1'b0; mem_write_in = 1'b0;
        exp_stall = 0;
        #1;
        chk("rstwait req", 32'(dmem_req), 32'd0);
        chk("rstwait busy", 32'(mem_busy), 32'd0);
        chk("rstwait valid", 32'(valid_out), 32'd0);
        chk("rstwait stall", stall_cycles, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++) begin
            int kind = $urandom_range(0, 2);
            rv.v     = ($urandom_range(0, 7) != 0);
            rv.rd_en = (kind == 1);
            rv.wr_en = (kind == 2);
            rv.rw    = 1'($urandom_range(0, 1));
            rv.f3    = 3'($urandom_range(0, 7));
            if (rv.wr_en && (rv.f3 == 4 || rv.f3 == 5)) rv.f3 = rv.f3 - 3'd4;
            rv.alu   = $urandom;
            if ($urandom_range(0, 1) == 1) rv.alu[1:0] = 2'b00;
            rv.rs2   = $urandom;
            rv.rdata = $urandom;
            rv.rd    = 5'($urandom_range(0, 31));
            rv.dly   = $urandom_range(0, 3);
            rv.fl_idle = ($urandom_range(0, 9) == 0);
            rv.fl_k  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rv.dly) : -1;
            rv = model(rv);
            apply(rv, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
